keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 148 ++++++++++++++
 tb/tb_keypad_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - debounced 10-key + clear keypad encoder driving a BCD countdown timer loader
// Registered strobes only; a key held across reset must be released before it can load again.
module keypad_encoder #(
  parameter int DEBOUNCE   = 4,
  parameter int MAX_DIGITS = 3
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic [9:0] keys,
  input  logic       clear_key,
  input  logic       running,
  output logic [3:0] digit,
  output logic       loadn,
  output logic       timer_clearn,
  output logic [1:0] digit_count,
  output logic       key_error
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_LOAD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE);
  localparam logic [7:0] DB_M1   = 8'(DEBOUNCE - 1);
  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic [10:0] pat_q, pat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  digit_q, digit_d;
  logic        loadn_q, loadn_d;
  logic        clrn_q, clrn_d;
  logic [1:0]  count_q, count_d;
  logic        err_q, err_d;
  logic        armed_q, armed_d;

  logic [10:0] pat_now;
  logic        any_press;
  logic        multi_key;
  logic [3:0]  key_idx;

  assign pat_now   = {clear_key, keys};
  assign any_press = |pat_now;
  assign multi_key = |(pat_q[9:0] & (pat_q[9:0] - 10'd1));

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (pat_q[i]) key_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    loadn_d = 1'b1;
    clrn_d  = 1'b1;
    count_d = count_q;
    err_d   = 1'b0;
    armed_d = armed_q;
    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          pat_d   = pat_now;
          cnt_d   = 8'd0;
          // an unarmed press was already down at reset: wait for its release
          state_d = armed_q ? ST_DEBOUNCE : ST_RELEASE;
        end else begin
          armed_d = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (pat_now != pat_q) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_RELEASE;
          if (pat_q[10]) begin
            clrn_d  = 1'b0;
            count_d = 2'd0;
          end else if (multi_key) begin
            err_d = 1'b1;
          end else if (!running && (count_q < MAX_CNT)) begin
            state_d = ST_LOAD;
            loadn_d = 1'b0;
            digit_d = key_idx;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOAD: begin
        state_d = ST_RELEASE;
        cnt_d   = 8'd0;
        if (count_q < MAX_CNT) count_d = count_q + 2'd1;
      end
      ST_RELEASE: begin
        if (any_press) begin
          cnt_d = 8'd0;
        end else if (cnt_q == DB_M1) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
          armed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      pat_q   <= 11'd0;
      cnt_q   <= 8'd0;
      digit_q <= 4'd0;
      loadn_q <= 1'b1;
      clrn_q  <= 1'b1;
      count_q <= 2'd0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      loadn_q <= loadn_d;
      clrn_q  <= clrn_d;
      count_q <= count_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign digit        = digit_q;
  assign loadn        = loadn_q;
  assign timer_clearn = clrn_q;
  assign digit_count  = count_q;
  assign key_error    = err_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - table-driven scoreboard bench for keypad_encoder
module tb_keypad_encoder;

  localparam int DB   = 4;
  localparam int MAXD = 3;

  logic       CLK;
  logic       clear;
  logic [9:0] keys;
  logic       clear_key;
  logic       running;
  logic [3:0] digit;
  logic       loadn;
  logic       timer_clearn;
  logic [1:0] digit_count;
  logic       key_error;

  keypad_encoder #(.DEBOUNCE(DB), .MAX_DIGITS(MAXD)) dut (
    .CLK          (CLK),
    .clear        (clear),
    .keys         (keys),
    .clear_key    (clear_key),
    .running      (running),
    .digit        (digit),
    .loadn        (loadn),
    .timer_clearn (timer_clearn),
    .digit_count  (digit_count),
    .key_error    (key_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] k;
    logic       ck;
    logic       run;
    logic       ld;
    logic [3:0] dg;
    logic       er;
    logic       cl;
    logic [1:0] cnt;
  } vec_t;

  vec_t vt[10];
  int   exp_load_q[$];
  int   exp_clr_n;
  int   exp_err_n;
  int   checks;
  int   errors;
  logic prev_loadn;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!clear) begin
      if (!loadn) begin
        checks++;
        if (exp_load_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_loadn: got digit %0d expected no load", digit);
        end else begin
          int e;
          e = exp_load_q.pop_front();
          if (int'(digit) != e) begin
            errors++;
            $display("FAIL load_digit: got %0d expected %0d", digit, e);
          end
        end
        checks++;
        if (!prev_loadn) begin
          errors++;
          $display("FAIL loadn_width: got low 2 cycles expected 1");
        end
        checks++;
        if (!timer_clearn) begin
          errors++;
          $display("FAIL strobe_overlap: got loadn=0 timer_clearn=0 expected not both low");
        end
      end
      if (!timer_clearn) begin
        checks++;
        if (exp_clr_n == 0) begin
          errors++;
          $display("FAIL unexpected_timer_clearn: got 0 expected 1");
        end else exp_clr_n--;
      end
      if (key_error) begin
        checks++;
        if (exp_err_n == 0) begin
          errors++;
          $display("FAIL unexpected_key_error: got 1 expected 0");
        end else exp_err_n--;
      end
    end
    prev_loadn = loadn;
  end

  task automatic press(input logic [9:0] k, input logic ck);
    keys = k;
    clear_key = ck;
    repeat (DB + 6) @(negedge CLK);
    keys = 10'd0;
    clear_key = 1'b0;
    repeat (DB + 3) @(negedge CLK);
  endtask

  task automatic check_pending(input string tag);
    check({tag, "_pending_load"}, exp_load_q.size(), 0);
    check({tag, "_pending_clr"}, exp_clr_n, 0);
    check({tag, "_pending_err"}, exp_err_n, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int first_low;
    int nlow;
    bit found;
    checks = 0; errors = 0; exp_clr_n = 0; exp_err_n = 0; prev_loadn = 1'b1;
    clear = 1'b1; keys = 10'd0; clear_key = 1'b0; running = 1'b0;

    vt[0] = '{10'h002, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd1};
    vt[1] = '{10'h008, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 2'd2};
    vt[2] = '{10'h001, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd3};
    vt[3] = '{10'h020, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd3};
    vt[4] = '{10'h006, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd3};
    vt[5] = '{10'h080, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0};
    vt[6] = '{10'h080, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0};
    vt[7] = '{10'h000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0};
    vt[8] = '{10'h200, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 2'd1};
    vt[9] = '{10'h3ff, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 2'd1};

    repeat (3) @(negedge CLK);
    #1;
    check("rst_digit", digit, 0);
    check("rst_loadn", loadn, 1);
    check("rst_timer_clearn", timer_clearn, 1);
    check("rst_digit_count", digit_count, 0);
    check("rst_key_error", key_error, 0);
    @(negedge CLK);
    clear = 1'b0;
    @(negedge CLK);

    exp_load_q.push_back(1);
    keys = 10'h002;
    first_low = -1;
    nlow = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (!loadn) begin
        nlow++;
        if (first_low < 0) first_low = c;
      end
    end
    check("latency_cycle", first_low, DB + 1);
    check("held_strobes", nlow, 1);
    check("latency_digit", digit, 1);
    check("latency_count", digit_count, 1);
    keys = 10'd0;
    repeat (DB + 3) @(negedge CLK);
    check_pending("latency");

    for (int c = 0; c < 20; c++) begin
      keys = (((c / 2) % 2) == 0) ? 10'h010 : 10'h000;
      @(negedge CLK);
    end
    keys = 10'd0;
    @(negedge CLK);
    check("bounce_no_load", exp_load_q.size(), 0);
    exp_load_q.push_back(4);
    press(10'h010, 1'b0);
    check("bounce_digit", digit, 4);
    check("bounce_count", digit_count, 2);
    check_pending("bounce");

    do_reset();
    for (int i = 0; i < 10; i++) begin
      running = vt[i].run;
      if (vt[i].ld) exp_load_q.push_back(int'(vt[i].dg));
      if (vt[i].er) exp_err_n++;
      if (vt[i].cl) exp_clr_n++;
      press(vt[i].k, vt[i].ck);
      running = 1'b0;
      check($sformatf("vec%0d_count", i), digit_count, vt[i].cnt);
      check($sformatf("vec%0d_digit", i), digit, vt[i].dg);
      check_pending($sformatf("vec%0d", i));
    end

    exp_load_q.push_back(8);
    keys = 10'h100;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge CLK);
      if (!loadn) found = 1'b1;
    end
    check("midload_found", found, 1);
    #1 clear = 1'b1;
    #1;
    check("midload_loadn", loadn, 1);
    check("midload_digit", digit, 0);
    check("midload_count", digit_count, 0);
    check("midload_timer_clearn", timer_clearn, 1);
    check("midload_key_error", key_error, 0);
    @(negedge CLK);
    clear = 1'b0;
    exp_load_q.delete();
    repeat (20) @(negedge CLK);
    check("held_after_reset_count", digit_count, 0);
    keys = 10'd0;
    repeat (DB + 3) @(negedge CLK);
    exp_load_q.push_back(8);
    press(10'h100, 1'b0);
    check("repress_digit", digit, 8);
    check("repress_count", digit_count, 1);
    check_pending("repress");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
